// File: rtl/nrs_ls_estimator_pkg.sv
// Shared types and constants for the NRS least-squares estimator and its
// conjugate-multiply helper.
package nrs_ls_estimator_pkg;

  localparam int WIDTH_REG_DEF = 16;
  localparam int IQ_WIDTH_DEF  = 16;

  // NRS bit value that maps to -1 (the other value maps to +1)
  localparam logic BPSK_NEG_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } est_state_e;

endpackage

// File: rtl/nrs_ls_estimator_if.sv
// Bundles the NRS read port, pilot stream and estimate output of the
// LS estimator; slave is the estimator's view, master the environment's.
interface nrs_ls_estimator_if
  import nrs_ls_estimator_pkg::*;
#(
  parameter int WIDTH_REG = WIDTH_REG_DEF,
  parameter int LINES     = $clog2(WIDTH_REG),
  parameter int IQ_WIDTH  = IQ_WIDTH_DEF
) ();

  logic                       NRS_gen_ready;
  logic                       nrs_est_r;
  logic                       nrs_est_i;
  logic [LINES-1:0]           rd_addr_est;
  logic                       est_ack;

  logic                       pilot_valid;
  logic                       pilot_ready;
  logic signed [IQ_WIDTH-1:0] pilot_r;
  logic signed [IQ_WIDTH-1:0] pilot_i;

  logic                       h_valid;
  logic signed [IQ_WIDTH-1:0] h_r;
  logic signed [IQ_WIDTH-1:0] h_i;
  logic [LINES-1:0]           h_idx;

  modport slave (
    input  NRS_gen_ready, nrs_est_r, nrs_est_i, pilot_valid, pilot_r, pilot_i,
    output rd_addr_est, est_ack, pilot_ready, h_valid, h_r, h_i, h_idx
  );

  modport master (
    output NRS_gen_ready, nrs_est_r, nrs_est_i, pilot_valid, pilot_r, pilot_i,
    input  rd_addr_est, est_ack, pilot_ready, h_valid, h_r, h_i, h_idx
  );

endinterface

// File: rtl/nrs_conj_mult.sv
// Combinational y * conj(c) / 2 for a BPSK-per-rail NRS symbol c = cr + j*ci,
// floor-halved and truncated back to IQ_WIDTH.
module nrs_conj_mult
  import nrs_ls_estimator_pkg::*;
#(
  parameter int IQ_WIDTH = IQ_WIDTH_DEF
) (
  input  logic signed [IQ_WIDTH-1:0] yr_i,
  input  logic signed [IQ_WIDTH-1:0] yi_i,
  input  logic                       cr_bit_i,
  input  logic                       ci_bit_i,
  output logic signed [IQ_WIDTH-1:0] hr_o,
  output logic signed [IQ_WIDTH-1:0] hi_o
);

  localparam int SW = IQ_WIDTH + 1;

  logic signed [SW-1:0] yr_w, yi_w;
  logic signed [SW-1:0] yr_cr, yi_ci, yi_cr, yr_ci;
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [SW-1:0] re_half, im_half;

  // One extra bit keeps -(-2^(IQ_WIDTH-1)) exact before halving
  always_comb begin
    yr_w    = {yr_i[IQ_WIDTH-1], yr_i};
    yi_w    = {yi_i[IQ_WIDTH-1], yi_i};
    yr_cr   = (cr_bit_i == BPSK_NEG_BIT) ? -yr_w : yr_w;
    yi_cr   = (cr_bit_i == BPSK_NEG_BIT) ? -yi_w : yi_w;
    yi_ci   = (ci_bit_i == BPSK_NEG_BIT) ? -yi_w : yi_w;
    yr_ci   = (ci_bit_i == BPSK_NEG_BIT) ? -yr_w : yr_w;
    re_sum  = yr_cr + yi_ci;
    im_sum  = yi_cr - yr_ci;
    re_half = re_sum >>> 1;
    im_half = im_sum >>> 1;
    hr_o    = $signed(re_half[IQ_WIDTH-1:0]);
    hi_o    = $signed(im_half[IQ_WIDTH-1:0]);
  end

endmodule

// File: rtl/nrs_ls_estimator.sv
// LS channel estimator over one NRS set: H = Y*conj(c)/2 per pilot, two-stage
// pipeline, one est_ack pulse to the generator after the last estimate.
//
//   state    | meaning
//   ST_IDLE  | wait for rising NRS_gen_ready
//   ST_RUN   | accept pilots, idx = NRS read address
//   ST_DRAIN | wait for the last pilot to leave stage 1
//   ST_ACK   | est_ack pulse, set consumed
module nrs_ls_estimator
  import nrs_ls_estimator_pkg::*;
#(
  parameter int WIDTH_REG = WIDTH_REG_DEF,
  parameter int LINES     = $clog2(WIDTH_REG),
  parameter int IQ_WIDTH  = IQ_WIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              new_frame,
  nrs_ls_estimator_if.slave bus
);

  localparam logic [LINES-1:0] LAST_IDX = LINES'(WIDTH_REG - 1);

  est_state_e                 state_q, state_d;
  logic [LINES-1:0]           idx_q, idx_d;
  logic                       ready_q;
  logic                       run_active, ack_active, accept;

  logic                       v1_q, cr1_q, ci1_q;
  logic signed [IQ_WIDTH-1:0] yr1_q, yi1_q;
  logic [LINES-1:0]           idx1_q;
  logic                       v2_q;
  logic signed [IQ_WIDTH-1:0] hr_q, hi_q, hr_c, hi_c;
  logic [LINES-1:0]           hidx_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    run_active = 1'b0;
    ack_active = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.NRS_gen_ready && !ready_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        run_active = 1'b1;
        if (bus.pilot_valid) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            idx_d = idx_q + LINES'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!v1_q) state_d = ST_ACK;
      end
      ST_ACK: begin
        ack_active = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Frame boundary abandons the set without acknowledging it
    if (new_frame) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end
  end

  assign accept = run_active & bus.pilot_valid;

  nrs_conj_mult #(.IQ_WIDTH(IQ_WIDTH)) u_conj_mult (
    .yr_i     (yr1_q),
    .yi_i     (yi1_q),
    .cr_bit_i (cr1_q),
    .ci_bit_i (ci1_q),
    .hr_o     (hr_c),
    .hi_o     (hi_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      v1_q    <= 1'b0;
      cr1_q   <= 1'b0;
      ci1_q   <= 1'b0;
      yr1_q   <= '0;
      yi1_q   <= '0;
      idx1_q  <= '0;
      v2_q    <= 1'b0;
      hr_q    <= '0;
      hi_q    <= '0;
      hidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= bus.NRS_gen_ready;
      v1_q    <= accept & ~new_frame;
      v2_q    <= v1_q & ~new_frame;
      if (accept) begin
        yr1_q  <= bus.pilot_r;
        yi1_q  <= bus.pilot_i;
        cr1_q  <= bus.nrs_est_r;
        ci1_q  <= bus.nrs_est_i;
        idx1_q <= idx_q;
      end
      if (v1_q) begin
        hr_q   <= hr_c;
        hi_q   <= hi_c;
        hidx_q <= idx1_q;
      end
    end
  end

  assign bus.pilot_ready = run_active;
  assign bus.est_ack     = ack_active;
  assign bus.rd_addr_est = idx_q;
  assign bus.h_valid     = v2_q;
  assign bus.h_r         = hr_q;
  assign bus.h_i         = hi_q;
  assign bus.h_idx       = hidx_q;

endmodule

// File: tb/tb_nrs_ls_estimator.sv
// Directed bench for nrs_ls_estimator: hand-computed estimates, a full
// 16-pilot run on a known NRS pattern, frame abort, reset abort and re-arm.
module tb_nrs_ls_estimator;

  localparam int WR  = 16;
  localparam int IQW = 16;

  logic clk = 1'b0;
  logic rst;
  logic new_frame;

  nrs_ls_estimator_if #(.WIDTH_REG(WR), .IQ_WIDTH(IQW)) bus ();

  nrs_ls_estimator #(.WIDTH_REG(WR), .IQ_WIDTH(IQW)) dut (
    .clk       (clk),
    .rst       (rst),
    .new_frame (new_frame),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Generator register model: combinational read at rd_addr_est
  logic [WR-1:0] pat_r, pat_i;
  assign bus.nrs_est_r = pat_r[bus.rd_addr_est];
  assign bus.nrs_est_i = pat_i[bus.rd_addr_est];

  int n_chk  = 0;
  int n_pass = 0;

  int pil_r [WR];
  int pil_i [WR];
  int exp_hr[WR];
  int exp_hi[WR];

  // Hand-computed vectors: pilot, NRS bits, expected estimate
  int   va_yr[8] = '{1000, 1000, 1000, -32768, -32768, 3, -7, -1};
  int   va_yi[8] = '{-2000, -2000, -2000, -32768, -32768, 0, 5, 0};
  logic va_br[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic va_bi[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  int   va_hr[8] = '{-500, -1500, 500, 0, -32768, 1, 6, -1};
  int   va_hi[8] = '{-1500, 500, 1500, -32768, 0, -2, 1, 0};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic load_hand();
    for (int k = 0; k < WR; k++) begin
      pil_r[k]  = va_yr[k % 8];
      pil_i[k]  = va_yi[k % 8];
      pat_r[k]  = va_br[k % 8];
      pat_i[k]  = va_bi[k % 8];
      exp_hr[k] = va_hr[k % 8];
      exp_hi[k] = va_hi[k % 8];
    end
  endtask

  task automatic load_pattern();
    int cr, ci;
    pat_r = 16'hA5C3;
    pat_i = 16'h3C5A;
    for (int k = 0; k < WR; k++) begin
      pil_r[k]  = 1000 * k - 7000;
      pil_i[k]  = 3000 - 450 * k;
      cr        = pat_r[k] ? -1 : 1;
      ci        = pat_i[k] ? -1 : 1;
      exp_hr[k] = (pil_r[k] * cr + pil_i[k] * ci) >>> 1;
      exp_hi[k] = (pil_i[k] * cr - pil_r[k] * ci) >>> 1;
    end
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (!bus.pilot_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " run start"}, int'(bus.pilot_ready), 1);
  endtask

  task automatic drive_pilot(input int k);
    bus.pilot_valid = 1'b1;
    bus.pilot_r     = 16'(pil_r[k]);
    bus.pilot_i     = 16'(pil_i[k]);
  endtask

  // Back-to-back run; c counts cycles from the first accept
  task automatic run_b2b(input string tag);
    wait_run(tag);
    for (int c = 0; c <= 20; c++) begin
      chk($sformatf("%s ready c%0d", tag, c), int'(bus.pilot_ready), int'(c < WR));
      if (c < WR) chk($sformatf("%s rd_addr c%0d", tag, c), int'(bus.rd_addr_est), c);
      chk($sformatf("%s h_valid c%0d", tag, c), int'(bus.h_valid), int'(c >= 2 && c < WR + 2));
      if (c >= 2 && c < WR + 2) begin
        chk($sformatf("%s h_idx c%0d", tag, c), int'(bus.h_idx), c - 2);
        chk($sformatf("%s h_r c%0d", tag, c), int'(bus.h_r), exp_hr[c-2]);
        chk($sformatf("%s h_i c%0d", tag, c), int'(bus.h_i), exp_hi[c-2]);
      end
      chk($sformatf("%s est_ack c%0d", tag, c), int'(bus.est_ack), int'(c == WR + 2));
      if (c < WR) drive_pilot(c);
      else bus.pilot_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " est_ack"}, int'(bus.est_ack), 0);
    chk({tag, " pilot_ready"}, int'(bus.pilot_ready), 0);
    chk({tag, " h_valid"}, int'(bus.h_valid), 0);
    chk({tag, " h_r"}, int'(bus.h_r), 0);
    chk({tag, " h_i"}, int'(bus.h_i), 0);
    chk({tag, " h_idx"}, int'(bus.h_idx), 0);
    chk({tag, " rd_addr"}, int'(bus.rd_addr_est), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b0;
    new_frame         = 1'b0;
    bus.NRS_gen_ready = 1'b0;
    bus.pilot_valid   = 1'b0;
    bus.pilot_r       = '0;
    bus.pilot_i       = '0;
    pat_r             = '0;
    pat_i             = '0;

    #12;
    check_all_zero("reset");

    @(negedge clk);
    rst = 1'b1;
    load_hand();
    @(negedge clk);
    bus.NRS_gen_ready = 1'b1;
    run_b2b("hand");

    // Generator ready still high: no rising edge, no second run
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("hold ready c%0d", c), int'(bus.pilot_ready), 0);
      chk($sformatf("hold est_ack c%0d", c), int'(bus.est_ack), 0);
      @(negedge clk);
    end

    bus.NRS_gen_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load_pattern();
    bus.NRS_gen_ready = 1'b1;
    run_b2b("pat");

    // Frame abort after pilot 7
    bus.NRS_gen_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.NRS_gen_ready = 1'b1;
    wait_run("abort");
    for (int c = 0; c < 8; c++) begin
      drive_pilot(c);
      @(negedge clk);
    end
    chk("abort h_valid pilot6", int'(bus.h_valid), 1);
    chk("abort h_idx pilot6", int'(bus.h_idx), 6);
    bus.pilot_valid = 1'b0;
    new_frame       = 1'b1;
    @(negedge clk);
    new_frame       = 1'b0;
    bus.pilot_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("abort h_valid c%0d", c), int'(bus.h_valid), 0);
      chk($sformatf("abort est_ack c%0d", c), int'(bus.est_ack), 0);
      chk($sformatf("abort ready c%0d", c), int'(bus.pilot_ready), 0);
      chk($sformatf("abort rd_addr c%0d", c), int'(bus.rd_addr_est), 0);
      @(negedge clk);
    end
    bus.pilot_valid = 1'b0;

    // Asynchronous reset after 5 pilots, then restart from idx 0
    bus.NRS_gen_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.NRS_gen_ready = 1'b1;
    wait_run("midrst");
    for (int c = 0; c < 5; c++) begin
      drive_pilot(c);
      @(negedge clk);
    end
    bus.pilot_valid = 1'b0;
    chk("midrst pre h_valid", int'(bus.h_valid), 1);
    chk("midrst pre rd_addr", int'(bus.rd_addr_est), 5);
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b1;
    run_b2b("restart");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
